// File: rtl/i2c_target_if.sv
// ---------------------------------------------------------------------------
// i2c_target_if
//   Bundles the pad-side I2C lines and the register-file access port of the
//   I2C target.
//
//   Signals:
//     scl_in   : raw SCL pad input (asynchronous to clk)
//     sda_in   : raw SDA pad input (asynchronous to clk)
//     sda_oe   : 1 = pull SDA low, 0 = release SDA (open drain)
//     reg_addr : current register pointer
//     wr_data  : received data byte, valid while wr_en is high
//     wr_en    : one-cycle register write strobe
//     rd_data  : register contents at reg_addr (combinational from reg file)
//     rd_en    : one-cycle read strobe; rd_data is captured in that cycle
//     busy     : high from START to STOP
//
//   Modports:
//     slave  : the I2C target block
//     master : the pad ring / register file / test environment around it
// ---------------------------------------------------------------------------
interface i2c_target_if #(
    parameter int PTR_W = 8
);
    logic             scl_in;
    logic             sda_in;
    logic             sda_oe;
    logic [PTR_W-1:0] reg_addr;
    logic [7:0]       wr_data;
    logic             wr_en;
    logic [7:0]       rd_data;
    logic             rd_en;
    logic             busy;

    modport slave (
        input  scl_in, sda_in, rd_data,
        output sda_oe, reg_addr, wr_data, wr_en, rd_en, busy
    );

    modport master (
        output scl_in, sda_in, rd_data,
        input  sda_oe, reg_addr, wr_data, wr_en, rd_en, busy
    );
endinterface

// File: rtl/i2c_target.sv
// ---------------------------------------------------------------------------
// i2c_target
//   I2C target front end for on-chip register access. SCL/SDA are
//   oversampled on clk (clk must be at least 8x the SCL rate), START / STOP /
//   repeated START are decoded, the 7-bit address is matched, and each
//   transfer becomes single-cycle write/read strobes on a register file
//   addressed by an auto-incrementing pointer. SDA is only ever pulled low
//   or released.
//
//   Parameters:
//     TGT_ADDR : own 7-bit address (default 7'h42)
//     PTR_W    : register pointer width (default 8); must match the
//                interface instance's PTR_W
//
//   Ports:
//     clk   : system clock
//     reset : synchronous, active-low
//     bus   : i2c_target_if.slave (pad lines and register-file port)
//
//   Optional feature:
//     I2C_TGT_GCALL_EN : when defined, the general-call address 7'h00 with
//                        R/W=0 is also ACKed and handled as a normal write.
//                        7'h00 with R/W=1 is always NACKed.
// ---------------------------------------------------------------------------
module i2c_target #(
    parameter logic [6:0] TGT_ADDR = 7'h42,
    parameter int         PTR_W    = 8
) (
    input logic         clk,
    input logic         reset,
    i2c_target_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } state_t;

    state_t state_q, state_d;

    // Input conditioning: 2-flop synchronizer plus one edge-detect flop.
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_dly_q, sda_dly_q;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;

    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             rw_q, rw_d;
    logic             ptr_pend_q, ptr_pend_d;
    logic             ack_ok_q, ack_ok_d;
    logic             sda_oe_q, sda_oe_d;
    logic [PTR_W-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             wr_en_q, wr_en_d;
    logic             rd_en_q, rd_en_d;
    logic             busy_q, busy_d;

    logic addr_hit, gcall_hit;

    // Synchronizers reset to the idle-bus level so leaving reset never
    // fabricates an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], bus.scl_in};
            sda_sync_q <= {sda_sync_q[0], bus.sda_in};
            scl_dly_q  <= scl_s;
            sda_dly_q  <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_dly_q;
    assign scl_fall  = ~scl_s & scl_dly_q;
    // SCL must be high both before and after the SDA edge, so an SDA change
    // that races an SCL edge is never mistaken for START/STOP.
    assign start_det = scl_s & scl_dly_q & ~sda_s & sda_dly_q;
    assign stop_det  = scl_s & scl_dly_q & sda_s & ~sda_dly_q;

    assign addr_hit = (shift_q[7:1] == TGT_ADDR);
`ifdef I2C_TGT_GCALL_EN
    // Only the write form of general call is accepted; 8'h01 misses.
    assign gcall_hit = (shift_q == 8'h00);
`else
    assign gcall_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        ptr_pend_d = ptr_pend_q;
        ack_ok_d   = ack_ok_q;
        sda_oe_d   = sda_oe_q;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        busy_d     = busy_q;

        // Pointer advances in the cycle after a write strobe.
        if (wr_en_q) begin
            reg_addr_d = reg_addr_q + PTR_W'(1);
        end

        // The read strobe is issued on the SCL fall; rd_data is captured and
        // bit 7 is put on SDA in the strobe cycle, still early in SCL low.
        if (rd_en_q && (state_q == RD_BYTE)) begin
            shift_d  = bus.rd_data;
            sda_oe_d = ~bus.rd_data[7];
            bitcnt_d = 4'd1;
        end

        case (state_q)
            IDLE: begin
                sda_oe_d = 1'b0;
            end

            ADDR: begin
                if (scl_rise) begin
                    shift_d  = {shift_q[6:0], sda_s};
                    bitcnt_d = bitcnt_q + 4'd1;
                end else if (scl_fall && (bitcnt_q == 4'd8)) begin
                    if (addr_hit || gcall_hit) begin
                        sda_oe_d = 1'b1;
                        rw_d     = shift_q[0];
                        state_d  = ADDR_ACK;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = IGNORE;
                    end
                end
            end

            ADDR_ACK: begin
                if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    bitcnt_d = 4'd0;
                    if (!rw_q) begin
                        ptr_pend_d = 1'b1;
                        state_d    = WR_BYTE;
                    end else begin
                        rd_en_d = 1'b1;
                        state_d = RD_BYTE;
                    end
                end
            end

            WR_BYTE: begin
                if (scl_rise) begin
                    shift_d  = {shift_q[6:0], sda_s};
                    bitcnt_d = bitcnt_q + 4'd1;
                end else if (scl_fall && (bitcnt_q == 4'd8)) begin
                    sda_oe_d = 1'b1;
                    if (ptr_pend_q) begin
                        reg_addr_d = PTR_W'(shift_q);
                        ptr_pend_d = 1'b0;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = shift_q;
                    end
                    state_d = WR_ACK;
                end
            end

            WR_ACK: begin
                if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    bitcnt_d = 4'd0;
                    state_d  = WR_BYTE;
                end
            end

            RD_BYTE: begin
                // bitcnt counts bits already presented on SDA.
                if (scl_fall) begin
                    if (bitcnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        ack_ok_d = 1'b0;
                        state_d  = RD_ACK;
                    end else begin
                        sda_oe_d = ~shift_q[6];
                        shift_d  = {shift_q[6:0], 1'b0};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
            end

            RD_ACK: begin
                if (scl_rise) begin
                    reg_addr_d = reg_addr_q + PTR_W'(1);
                    if (sda_s) begin
                        state_d = IGNORE;
                    end else begin
                        ack_ok_d = 1'b1;
                    end
                end else if (scl_fall && ack_ok_q) begin
                    rd_en_d  = 1'b1;
                    bitcnt_d = 4'd0;
                    state_d  = RD_BYTE;
                end
            end

            IGNORE: begin
                sda_oe_d = 1'b0;
            end

            default: begin
                sda_oe_d = 1'b0;
                state_d  = IDLE;
            end
        endcase

        if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d  = ADDR;
            bitcnt_d = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            bitcnt_q   <= 4'd0;
            rw_q       <= 1'b0;
            ptr_pend_q <= 1'b0;
            ack_ok_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            reg_addr_q <= '0;
            wr_data_q  <= 8'h00;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            rw_q       <= rw_d;
            ptr_pend_q <= ptr_pend_d;
            ack_ok_q   <= ack_ok_d;
            sda_oe_q   <= sda_oe_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
        end
    end

    // Shift register is pure datapath; its content is meaningless until a
    // full byte has been clocked in or loaded.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.reg_addr = reg_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.rd_en    = rd_en_q;
    assign bus.busy     = busy_q;

endmodule
